// File: rtl/solver_scheduler.sv
// Round-robin scheduler that shares one frame-buffer write port among row-interleaved pattern solvers.
// Optional FRAME_CYCLES_EN adds a saturating frame_cycles counter covering SRST..REL.
module solver_scheduler #(
   parameter int NUM_SOLVERS = 4,
   parameter int NUM_COLUMNS = 640,
   parameter int NUM_ROWS    = 480,
   parameter int ADDR_W      = 19
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [NUM_SOLVERS-1:0]   solver_ready,
   input  logic [4*NUM_SOLVERS-1:0] solver_data,
   output logic                     solver_reset,
   output logic [NUM_SOLVERS-1:0]   solver_cont,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [3:0]               mem_data,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic                     busy,
`ifdef FRAME_CYCLES_EN
   output logic [31:0]              frame_cycles,
`endif
   output logic                     frame_done
);

   localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
   localparam int ROW_W = $clog2(NUM_ROWS + NUM_SOLVERS + 1);
   localparam int GNT_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'((NUM_SOLVERS - 1) * NUM_COLUMNS + 1);

   typedef enum logic [2:0] {IDLE, SRST, ARB, WR, REL, DONE} state_t;

   state_t                state;
   logic [COL_W-1:0]      col  [NUM_SOLVERS];
   logic [ROW_W-1:0]      row  [NUM_SOLVERS];
   logic [ADDR_W-1:0]     addr [NUM_SOLVERS];
   logic [GNT_W-1:0]      rr;
   logic                  skip_rr;
   logic [NUM_SOLVERS-1:0] fin;
   logic [NUM_SOLVERS-1:0] eligible;
   logic                  all_fin;
   logic                  found;
   logic [GNT_W-1:0]      grant;
   logic [GNT_W:0]        probe;

   // A solver whose continue just pulsed still shows ready for one cycle, so it is masked right after REL.
   always_comb begin
      for (int i = 0; i < NUM_SOLVERS; i++) begin
         fin[i]      = (row[i] >= ROW_W'(NUM_ROWS));
         eligible[i] = solver_ready[i] & ~fin[i] & ~(skip_rr && (rr == GNT_W'(i)));
      end
      all_fin = &fin;
   end

   // Search upward from the last grant with wrap; the first eligible solver wins.
   always_comb begin
      found = 1'b0;
      grant = rr;
      probe = '0;
      for (int k = 1; k <= NUM_SOLVERS; k++) begin
         probe = {1'b0, rr} + (GNT_W+1)'(k);
         if (probe >= (GNT_W+1)'(NUM_SOLVERS))
            probe = probe - (GNT_W+1)'(NUM_SOLVERS);
         if (!found && eligible[probe[GNT_W-1:0]]) begin
            found = 1'b1;
            grant = probe[GNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         rr           <= GNT_W'(NUM_SOLVERS - 1);
         skip_rr      <= 1'b0;
         solver_reset <= 1'b0;
         solver_cont  <= '0;
         mem_addr     <= '0;
         mem_data     <= '0;
         mem_valid    <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
`ifdef FRAME_CYCLES_EN
         frame_cycles <= '0;
`endif
         for (int i = 0; i < NUM_SOLVERS; i++) begin
            col[i]  <= '0;
            row[i]  <= '0;
            addr[i] <= '0;
         end
      end else begin
         solver_reset <= 1'b0;
         solver_cont  <= '0;
`ifdef FRAME_CYCLES_EN
         if ((state == SRST || state == ARB || state == WR || state == REL) && frame_cycles != 32'hFFFF_FFFF)
            frame_cycles <= frame_cycles + 32'd1;
`endif
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= SRST;
                  solver_reset <= 1'b1;
                  busy         <= 1'b1;
                  frame_done   <= 1'b0;
`ifdef FRAME_CYCLES_EN
                  frame_cycles <= '0;
`endif
               end
            end
            SRST: begin
               for (int i = 0; i < NUM_SOLVERS; i++) begin
                  col[i]  <= '0;
                  row[i]  <= ROW_W'(i);
                  addr[i] <= ADDR_W'(i * NUM_COLUMNS);
               end
               skip_rr <= 1'b0;
               state   <= ARB;
            end
            ARB: begin
               skip_rr <= 1'b0;
               if (all_fin) begin
                  state      <= DONE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end else if (found) begin
                  rr        <= grant;
                  mem_addr  <= addr[grant];
                  mem_data  <= solver_data[{grant, 2'b00} +: 4];
                  mem_valid <= 1'b1;
                  state     <= WR;
               end
            end
            WR: begin
               if (mem_ready) begin
                  mem_valid       <= 1'b0;
                  solver_cont[rr] <= 1'b1;
                  state           <= REL;
               end
            end
            REL: begin
               // End of a row jumps over the rows owned by the other solvers.
               if (col[rr] == COL_W'(NUM_COLUMNS - 1)) begin
                  col[rr]  <= '0;
                  row[rr]  <= row[rr] + ROW_W'(NUM_SOLVERS);
                  addr[rr] <= addr[rr] + ROW_STEP;
               end else begin
                  col[rr]  <= col[rr] + COL_W'(1);
                  addr[rr] <= addr[rr] + ADDR_W'(1);
               end
               skip_rr <= 1'b1;
               state   <= ARB;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_solver_scheduler.sv
// Directed bench for solver_scheduler: a 2x4x2 instance (dut) and a 2x4x3 instance (dut3) share stimulus.
// With FRAME_CYCLES_EN defined the frame_cycles port is also checked.
module tb_solver_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] solver_ready = '0;
   logic [7:0] solver_data = '0;
   logic       mem_ready = 1'b0;

   logic       solver_reset, mem_valid, busy, frame_done;
   logic [1:0] solver_cont;
   logic [3:0] mem_addr, mem_data;
   logic       solver_reset_b, mem_valid_b, busy_b, frame_done_b;
   logic [1:0] solver_cont_b;
   logic [3:0] mem_addr_b, mem_data_b;
`ifdef FRAME_CYCLES_EN
   logic [31:0] frame_cycles, frame_cycles_b;
`endif

   int total = 0;
   int bad = 0;

   logic [3:0] q_addr [$];
   logic [3:0] q_data [$];
   logic [1:0] q_cont [$];
   int b_writes = 0;
   int b_cont0 = 0;
   int b_cont1 = 0;

   logic [3:0] exp_addr [8] = '{4'd0, 4'd4, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7};

   always #5 clock = ~clock;

   solver_scheduler #(.NUM_SOLVERS(2), .NUM_COLUMNS(4), .NUM_ROWS(2), .ADDR_W(4)) dut (
      .clock(clock), .reset(reset), .start(start),
      .solver_ready(solver_ready), .solver_data(solver_data),
      .solver_reset(solver_reset), .solver_cont(solver_cont),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .busy(busy),
`ifdef FRAME_CYCLES_EN
      .frame_cycles(frame_cycles),
`endif
      .frame_done(frame_done)
   );

   solver_scheduler #(.NUM_SOLVERS(2), .NUM_COLUMNS(4), .NUM_ROWS(3), .ADDR_W(4)) dut3 (
      .clock(clock), .reset(reset), .start(start),
      .solver_ready(solver_ready), .solver_data(solver_data),
      .solver_reset(solver_reset_b), .solver_cont(solver_cont_b),
      .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_valid(mem_valid_b), .mem_ready(mem_ready),
      .busy(busy_b),
`ifdef FRAME_CYCLES_EN
      .frame_cycles(frame_cycles_b),
`endif
      .frame_done(frame_done_b)
   );

   // Log every accepted write and every continue pulse of both instances.
   always @(negedge clock) begin
      if (!reset) begin
         if (mem_valid && mem_ready) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_data);
         end
         if (solver_cont != 2'b00) q_cont.push_back(solver_cont);
         if (mem_valid_b && mem_ready) b_writes++;
         if (solver_cont_b[0]) b_cont0++;
         if (solver_cont_b[1]) b_cont1++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] rdy, input logic [7:0] dat, input logic mrdy);
      @(negedge clock);
      solver_ready = rdy;
      solver_data  = dat;
      mem_ready    = mrdy;
   endtask

   task automatic applyReset();
      @(negedge clock);
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pulseStart();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int limit, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < limit && !ok; n++) begin
         @(negedge clock);
         if (frame_done) ok = 1'b1;
      end
   endtask

   task automatic waitDoneB(input int limit, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < limit && !ok; n++) begin
         @(negedge clock);
         if (frame_done_b) ok = 1'b1;
      end
   endtask

   task automatic waitValid(input int limit, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < limit && !ok; n++) begin
         @(negedge clock);
         if (mem_valid) ok = 1'b1;
      end
   endtask

   // Both solvers always ready with data 3 (solver 0) and C (solver 1).
   task automatic checkFrame(input int mark, input int cmark);
      checkOutput("frame_write_count", q_addr.size() - mark, 8);
      checkOutput("frame_cont_count", q_cont.size() - cmark, 8);
      for (int j = 0; j < 8; j++) begin
         if (mark + j < q_addr.size()) begin
            checkOutput($sformatf("frame_addr%0d", j), q_addr[mark+j], exp_addr[j]);
            checkOutput($sformatf("frame_data%0d", j), q_data[mark+j], (j % 2 == 0) ? 4'h3 : 4'hC);
         end
         if (cmark + j < q_cont.size())
            checkOutput($sformatf("frame_cont%0d", j), q_cont[cmark+j], (j % 2 == 0) ? 2'b01 : 2'b10);
      end
   endtask

   initial begin
      bit ok;
      int mark, cmark, bw, b0, b1;
      logic [3:0] held_addr, held_data;

      // Reset state and start pulse with no solver ready.
      @(negedge clock);
      checkOutput("rst_mem_valid", mem_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      checkOutput("rst_solver_reset", solver_reset, 0);
      checkOutput("rst_solver_cont", solver_cont, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
`ifdef FRAME_CYCLES_EN
      checkOutput("rst_frame_cycles", frame_cycles, 0);
`endif
      applyReset();
      applyStimulus(2'b00, 8'h00, 1'b0);
      pulseStart();
      checkOutput("srst_pulse", solver_reset, 1);
      checkOutput("srst_busy", busy, 1);
      checkOutput("srst_no_valid", mem_valid, 0);
      @(posedge clock);
      #1;
      checkOutput("srst_one_cycle", solver_reset, 0);
      checkOutput("arb_busy", busy, 1);
      checkOutput("arb_no_valid", mem_valid, 0);

      // Full frame on dut, then the taller frame on dut3, then done holds until restart.
      applyReset();
      applyStimulus(2'b11, 8'hC3, 1'b1);
      mark = q_addr.size();
      cmark = q_cont.size();
      bw = b_writes;
      b0 = b_cont0;
      b1 = b_cont1;
      pulseStart();
      waitDone(100, ok);
      checkOutput("frame_done_timeout", ok, 1);
      checkOutput("done_busy", busy, 0);
`ifdef FRAME_CYCLES_EN
      checkOutput("frame_cycles", frame_cycles, 26);
`endif
      checkFrame(mark, cmark);
      waitDoneB(150, ok);
      checkOutput("rows3_done_timeout", ok, 1);
      checkOutput("rows3_writes", b_writes - bw, 12);
      checkOutput("rows3_solver0", b_cont0 - b0, 8);
      checkOutput("rows3_solver1", b_cont1 - b1, 4);
      repeat (3) @(negedge clock);
      checkOutput("done_holds", frame_done, 1);
`ifdef FRAME_CYCLES_EN
      checkOutput("frame_cycles_hold", frame_cycles, 26);
`endif
      applyStimulus(2'b00, 8'h00, 1'b0);
      pulseStart();
      checkOutput("restart_clears_done", frame_done, 0);
      checkOutput("restart_busy", busy, 1);
      checkOutput("restart_srst", solver_reset, 1);
`ifdef FRAME_CYCLES_EN
      checkOutput("restart_cycles_clear", frame_cycles, 0);
`endif

      // Backpressure: write held six cycles, continue one cycle after accept.
      applyReset();
      applyStimulus(2'b01, 8'h05, 1'b0);
      pulseStart();
      waitValid(20, ok);
      checkOutput("bp_valid_timeout", ok, 1);
      held_addr = mem_addr;
      held_data = mem_data;
      checkOutput("bp_addr", held_addr, 4'd0);
      checkOutput("bp_data", held_data, 4'h5);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clock);
         checkOutput($sformatf("bp_valid%0d", i), mem_valid, 1);
         checkOutput($sformatf("bp_addr_stable%0d", i), mem_addr, held_addr);
         checkOutput($sformatf("bp_data_stable%0d", i), mem_data, held_data);
         checkOutput($sformatf("bp_no_cont%0d", i), solver_cont, 2'b00);
         if (i == 5) mem_ready = 1'b1;
      end
      @(negedge clock);
      checkOutput("bp_cont_after_accept", solver_cont, 2'b01);
      checkOutput("bp_valid_dropped", mem_valid, 0);
      @(negedge clock);
      checkOutput("bp_cont_one_cycle", solver_cont, 2'b00);

      // Only solver 1 ready: it alone writes its row, solver 0 is never granted.
      applyReset();
      applyStimulus(2'b10, 8'hA0, 1'b1);
      mark = q_addr.size();
      cmark = q_cont.size();
      pulseStart();
      repeat (40) @(negedge clock);
      checkOutput("s1_write_count", q_addr.size() - mark, 4);
      checkOutput("s1_cont_count", q_cont.size() - cmark, 4);
      for (int j = 0; j < 4; j++) begin
         if (mark + j < q_addr.size()) begin
            checkOutput($sformatf("s1_addr%0d", j), q_addr[mark+j], 4'(4 + j));
            checkOutput($sformatf("s1_data%0d", j), q_data[mark+j], 4'hA);
         end
         if (cmark + j < q_cont.size())
            checkOutput($sformatf("s1_cont%0d", j), q_cont[cmark+j], 2'b10);
      end
      checkOutput("s1_still_busy", busy, 1);
      checkOutput("s1_not_done", frame_done, 0);

      // Async reset in WR aborts immediately; a new frame replays from address 0.
      applyReset();
      applyStimulus(2'b11, 8'hC3, 1'b0);
      pulseStart();
      waitValid(20, ok);
      checkOutput("abort_valid_timeout", ok, 1);
      reset = 1'b1;
      #1;
      checkOutput("abort_valid", mem_valid, 0);
      checkOutput("abort_cont", solver_cont, 2'b00);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", frame_done, 0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(2'b11, 8'hC3, 1'b1);
      mark = q_addr.size();
      cmark = q_cont.size();
      pulseStart();
      waitDone(100, ok);
      checkOutput("replay_done_timeout", ok, 1);
      checkFrame(mark, cmark);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
